// File: rtl/router_pkg.sv
// Shared router definitions: flit type encoding, type-field decode helpers
// and the output-controller FSM states.
package router_pkg;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_TAIL   = 2'b01,
        FT_HEAD   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    // Bit positions inside the 2-bit type field (flit[FLIT_W-1 -: 2]).
    localparam int TYPE_HI = 1;
    localparam int TYPE_LO = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } out_ctrl_state_t;

    function automatic logic is_head(input flit_type_t t);
        return t[TYPE_HI];
    endfunction

    function automatic logic is_tail(input flit_type_t t);
        return t[TYPE_LO];
    endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching with wrap-around.
module router_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx,
    output logic          any
);

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any      = 1'b1;
                pick_idx = IW'((int'(ptr) + k) % N);
            end
        end
        pick[pick_idx] = any;
    end

endmodule

// File: rtl/router_output_ctrl.sv
// Per-output-port switch controller: round-robin head arbitration, wormhole
// lock until tail, credit-gated forwarding and a one-stage output register.
module router_output_ctrl
    import router_pkg::*;
#(
    parameter  int NUM_IN  = 4,
    parameter  int FLIT_W  = 34,
    parameter  int CREDITS = 4,
    localparam int CW      = $clog2(CREDITS + 1),
    localparam int IW      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_IN-1:0]              in_valid,
    input  logic [NUM_IN-1:0][FLIT_W-1:0]  in_flit,
    output logic [NUM_IN-1:0]              in_pop,
    output logic                           out_valid,
    output logic [FLIT_W-1:0]              out_flit,
    input  logic                           credit_in,
    output logic [CW-1:0]                  credit_count,
    output logic                           credit_err
);

    out_ctrl_state_t   state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic              err_q, err_d;
    logic              out_valid_q;
    logic [FLIT_W-1:0] out_flit_q;

    logic [NUM_IN-1:0] head_req, pick_oh;
    logic [IW-1:0]     pick_idx, fwd_idx;
    logic              pick_any, has_credit, fwd;
    logic [FLIT_W-1:0] fwd_flit;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++)
            head_req[i] = in_valid[i] && is_head(flit_type_t'(in_flit[i][FLIT_W-1 -: 2]));
    end

    router_rr_pick #(.N(NUM_IN), .IW(IW)) u_pick (
        .req      (head_req),
        .ptr      (rr_q),
        .pick     (pick_oh),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    // Forwarding only ever uses the registered count; a same-cycle credit waits.
    assign has_credit = (credit_q != '0);

    always_comb begin
        in_pop  = '0;
        fwd_idx = owner_q;
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        if (state_q == IDLE) begin
            fwd_idx = pick_idx;
            if (pick_any && has_credit) begin
                in_pop = pick_oh;
                rr_d   = (pick_idx == IW'(NUM_IN - 1)) ? '0 : pick_idx + 1'b1;
                if (!is_tail(flit_type_t'(in_flit[pick_idx][FLIT_W-1 -: 2]))) begin
                    state_d = LOCKED;
                    owner_d = pick_idx;
                end
            end
        end else if (in_valid[owner_q] && has_credit) begin
            in_pop[owner_q] = 1'b1;
            if (is_tail(flit_type_t'(in_flit[owner_q][FLIT_W-1 -: 2])))
                state_d = IDLE;
        end
        if (rst)
            in_pop = '0;
    end

    assign fwd      = |in_pop;
    assign fwd_flit = in_flit[fwd_idx];

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        case ({fwd, credit_in})
            2'b10:   credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CW'(CREDITS)) err_d = 1'b1;
                else                          credit_d = credit_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_q        <= '0;
            credit_q    <= CW'(CREDITS);
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            credit_q    <= credit_d;
            err_q       <= err_d;
            out_valid_q <= fwd;
            if (fwd)
                out_flit_q <= fwd_flit;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_flit     = out_flit_q;
    assign credit_count = credit_q;
    assign credit_err   = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_pop_onehot: assert ($onehot0(in_pop));
            a_pop_credit: assert (credit_q != '0 || in_pop == '0);
            a_pop_owner:  assert (state_q != LOCKED || (in_pop & ~(NUM_IN'(1) << owner_q)) == '0);
        end
    end

endmodule

// File: tb/tb_router_output_ctrl.sv
// Directed bench for router_output_ctrl: table-driven arbitration vectors
// plus hand sequences for credit stall, credit error and mid-packet reset.
module tb_router_output_ctrl;
    import router_pkg::*;

    localparam logic [1:0] H = 2'b10, B = 2'b00, T = 2'b01, S = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       in_valid;
    logic [3:0][33:0] in_flit;
    logic [3:0]       in_pop;
    logic             out_valid;
    logic [33:0]      out_flit;
    logic             credit_in;
    logic [2:0]       credit_count;
    logic             credit_err;

    int tests = 0;
    int fails = 0;

    router_output_ctrl #(.NUM_IN(4), .FLIT_W(34), .CREDITS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_flit      (in_flit),
        .in_pop       (in_pop),
        .out_valid    (out_valid),
        .out_flit     (out_flit),
        .credit_in    (credit_in),
        .credit_count (credit_count),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       v;
        logic [3:0][1:0]  ty;
        logic             ci;
        logic [3:0]       pop;
        logic [2:0]       cnt;
        out_ctrl_state_t  st;
        logic [1:0]       rr;
    } vec_t;

    function automatic vec_t V(input logic [3:0] v, input logic [7:0] ty, input logic ci,
                               input logic [3:0] pop, input logic [2:0] cnt,
                               input out_ctrl_state_t st, input logic [1:0] rr);
        vec_t r;
        r.v = v; r.ty = ty; r.ci = ci; r.pop = pop; r.cnt = cnt; r.st = st; r.rr = rr;
        return r;
    endfunction

    function automatic logic [33:0] fl(input logic [1:0] t, input int i, input int n);
        return {t, i[7:0], n[23:0]};
    endfunction

    function automatic logic [1:0] ty6(input int k);
        return (k == 0) ? H : ((k == 5) ? T : B);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[18];

    initial begin
        logic [33:0] exp_f;
        int k;

        // arbitration, wormhole lock and rotation vectors; ty = {in3,in2,in1,in0}
        tbl[0]  = V(4'b0101, {B,H,B,H}, 1'b0, 4'b0001, 3'd3, LOCKED, 2'd1);
        tbl[1]  = V(4'b0101, {B,H,B,B}, 1'b1, 4'b0001, 3'd3, LOCKED, 2'd1);
        tbl[2]  = V(4'b0101, {B,H,B,T}, 1'b1, 4'b0001, 3'd3, IDLE,   2'd1);
        tbl[3]  = V(4'b0100, {B,H,B,B}, 1'b1, 4'b0100, 3'd3, LOCKED, 2'd3);
        tbl[4]  = V(4'b0100, {B,B,B,B}, 1'b1, 4'b0100, 3'd3, LOCKED, 2'd3);
        tbl[5]  = V(4'b0100, {B,T,B,B}, 1'b1, 4'b0100, 3'd3, IDLE,   2'd3);
        tbl[6]  = V(4'b0000, {B,B,B,B}, 1'b1, 4'b0000, 3'd4, IDLE,   2'd3);
        tbl[7]  = V(4'b0010, {B,B,H,B}, 1'b1, 4'b0010, 3'd4, LOCKED, 2'd2);
        tbl[8]  = V(4'b1011, {H,B,B,B}, 1'b1, 4'b0010, 3'd4, LOCKED, 2'd2);
        tbl[9]  = V(4'b1011, {H,B,B,B}, 1'b1, 4'b0010, 3'd4, LOCKED, 2'd2);
        tbl[10] = V(4'b1011, {H,B,T,B}, 1'b1, 4'b0010, 3'd4, IDLE,   2'd2);
        tbl[11] = V(4'b1001, {H,B,B,B}, 1'b1, 4'b1000, 3'd4, LOCKED, 2'd0);
        tbl[12] = V(4'b1001, {T,B,B,B}, 1'b1, 4'b1000, 3'd4, IDLE,   2'd0);
        tbl[13] = V(4'b1111, {S,S,S,S}, 1'b1, 4'b0001, 3'd4, IDLE,   2'd1);
        tbl[14] = V(4'b1111, {S,S,S,S}, 1'b1, 4'b0010, 3'd4, IDLE,   2'd2);
        tbl[15] = V(4'b1111, {S,S,S,S}, 1'b1, 4'b0100, 3'd4, IDLE,   2'd3);
        tbl[16] = V(4'b1111, {S,S,S,S}, 1'b1, 4'b1000, 3'd4, IDLE,   2'd0);
        tbl[17] = V(4'b1111, {S,S,S,S}, 1'b1, 4'b0001, 3'd4, IDLE,   2'd1);

        rst = 1'b1; in_valid = '0; in_flit = '0; credit_in = 1'b0;
        tick(); tick();
        chk("rst out_valid", out_valid, 0);
        chk("rst out_flit", out_flit, 0);
        chk("rst credits", credit_count, 4);
        chk("rst credit_err", credit_err, 0);
        chk("rst state", dut.state_q, IDLE);
        chk("rst rr", dut.rr_q, 0);
        rst = 1'b0;

        for (int n = 0; n < 18; n++) begin
            in_valid  = tbl[n].v;
            credit_in = tbl[n].ci;
            for (int i = 0; i < 4; i++) in_flit[i] = fl(tbl[n].ty[i], i, n);
            #1;
            chk($sformatf("vec%0d in_pop", n), in_pop, tbl[n].pop);
            exp_f = '0;
            for (int i = 0; i < 4; i++) if (tbl[n].pop[i]) exp_f = fl(tbl[n].ty[i], i, n);
            tick();
            chk($sformatf("vec%0d out_valid", n), out_valid, |tbl[n].pop);
            if (|tbl[n].pop) chk($sformatf("vec%0d out_flit", n), out_flit, exp_f);
            chk($sformatf("vec%0d credits", n), credit_count, tbl[n].cnt);
            chk($sformatf("vec%0d state", n), dut.state_q, tbl[n].st);
            chk($sformatf("vec%0d rr", n), dut.rr_q, tbl[n].rr);
        end

        // credit exhaustion on a 6-flit packet, then a single credit pulse
        rst = 1'b1; in_valid = '0; in_flit = '0; credit_in = 1'b0;
        tick();
        rst = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 4'b0001;
            in_flit[0] = fl(ty6(k), 0, k);
            #1;
            chk($sformatf("stall c%0d in_pop", c), in_pop, (c < 4) ? 4'b0001 : 4'b0000);
            tick();
            chk($sformatf("stall c%0d out_valid", c), out_valid, c < 4);
            if (c < 4) begin
                chk($sformatf("stall c%0d out_flit", c), out_flit, fl(ty6(k), 0, k));
                k++;
            end
            chk($sformatf("stall c%0d credits", c), credit_count, (c < 4) ? 3 - c : 0);
        end
        credit_in = 1'b1;
        #1;
        chk("pulse same-cycle in_pop", in_pop, 4'b0000);
        tick();
        chk("pulse credits", credit_count, 1);
        chk("pulse out_valid", out_valid, 0);
        credit_in = 1'b0;
        #1;
        chk("after pulse in_pop", in_pop, 4'b0001);
        tick();
        chk("after pulse out_valid", out_valid, 1);
        chk("after pulse out_flit", out_flit, fl(ty6(4), 0, 4));
        chk("after pulse credits", credit_count, 0);
        k = 5;
        in_flit[0] = fl(ty6(k), 0, k);
        #1;
        chk("restall in_pop", in_pop, 4'b0000);
        tick();
        chk("restall out_valid", out_valid, 0);

        // forward and credit together at count 2, then overflow at count 4
        in_valid = '0; credit_in = 1'b1;
        tick(); tick();
        chk("refill credits", credit_count, 2);
        in_valid = 4'b0001;
        #1;
        chk("fwd+credit in_pop", in_pop, 4'b0001);
        tick();
        chk("fwd+credit credits", credit_count, 2);
        chk("fwd+credit out_flit", out_flit, fl(T, 0, 5));
        chk("fwd+credit state", dut.state_q, IDLE);
        in_valid = '0;
        tick(); tick();
        chk("full credits", credit_count, 4);
        chk("full credit_err", credit_err, 0);
        tick();
        chk("overflow credit_err", credit_err, 1);
        chk("overflow credits", credit_count, 4);
        credit_in = 1'b0;
        tick();
        chk("sticky credit_err", credit_err, 1);

        // reset mid-packet, then an immediate new head
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2 credit_err", credit_err, 0);
        in_valid = 4'b0100; in_flit = '0;
        in_flit[2] = fl(H, 2, 0);
        #1;
        chk("mid head in_pop", in_pop, 4'b0100);
        tick();
        in_flit[2] = fl(B, 2, 1);
        #1;
        chk("mid body in_pop", in_pop, 4'b0100);
        tick();
        chk("mid state", dut.state_q, LOCKED);
        in_flit[2] = fl(B, 2, 2);
        rst = 1'b1;
        #1;
        chk("rst forces in_pop", in_pop, 4'b0000);
        tick();
        chk("rst3 out_valid", out_valid, 0);
        chk("rst3 credits", credit_count, 4);
        chk("rst3 state", dut.state_q, IDLE);
        rst = 1'b0;
        in_valid = 4'b0010; in_flit = '0;
        in_flit[1] = fl(H, 1, 3);
        #1;
        chk("new head in_pop", in_pop, 4'b0010);
        tick();
        chk("new head out_valid", out_valid, 1);
        chk("new head out_flit", out_flit, fl(H, 1, 3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
